// File: rtl/pacman_pkg.sv
// Shared definitions for the tile RAM arbiter: FSM states, owner tags and
// the tile RAM address width.
package pacman_pkg;

    localparam int TILE_AW = 10;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_GAME = 2'd2
    } arb_owner_e;

    // Owner tag for a grant; game writes return no data so they tag NONE.
    function automatic arb_owner_e owner_of(input logic disp_gnt,
                                            input logic game_gnt,
                                            input logic game_we);
        arb_owner_e own;
        own = OWN_NONE;
        if (disp_gnt) begin
            own = OWN_DISP;
        end else if (game_gnt && !game_we) begin
            own = OWN_GAME;
        end else begin
            own = OWN_NONE;
        end
        return own;
    endfunction

endpackage

// File: rtl/tile_ram_arbiter_starve_cnt.sv
// Saturating wait counter for a starved game request; o_hit is high once the
// count has reached LIMIT and stays high until the request is granted.
module arb_starve_cnt #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);
    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    assign o_hit = (r_cnt >= CW'(LIMIT));

    // Count waiting cycles, clear on grant, saturate at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_inc && !o_hit) begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Tile RAM sequencer/arbiter: evaluator fill phase, then display-over-game
// priority on the single RAM port. Optional macro TILE_ARB_STARVE_EN lets a
// game request that has waited STARVE_LIMIT cycles steal one display slot.
module tile_ram_arbiter
    import pacman_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 64,
    parameter int          AW           = TILE_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          level_start,
    input  logic          init_we,
    input  logic [AW-1:0] init_addr,
    input  logic [7:0]    init_wdata,
    input  logic          init_done,
    output logic          fill_busy,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_miss,
    input  logic          game_req,
    input  logic          game_we,
    input  logic [AW-1:0] game_addr,
    input  logic [7:0]    game_wdata,
    output logic          game_gnt,
    output logic          game_rvalid,
    output logic [7:0]    rdata,
    output logic          disp_rvalid,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout
);

    if (STARVE_LIMIT == 0) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    arb_state_e    r_state, w_next_state;
    arb_owner_e    r_owner;
    logic [AW-1:0] r_last_addr;
    logic [AW-1:0] w_ram_addr;
    logic [7:0]    w_ram_din;
    logic          w_ram_we;
    logic          w_game_gnt;
    logic          w_disp_gnt;
    logic          w_disp_miss;
    logic          w_starve_win;

`ifdef TILE_ARB_STARVE_EN
    logic w_starve_hit;

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc ((r_state == ST_RUN) && game_req && !w_game_gnt),
        .i_clr (w_game_gnt),
        .o_hit (w_starve_hit)
    );

    assign w_starve_win = w_starve_hit && game_req && (r_state == ST_RUN);
`else
    assign w_starve_win = 1'b0;
`endif

    // Next state and combinational arbitration of the single RAM port.
    always_comb begin
        w_next_state = r_state;
        w_ram_addr   = r_last_addr;
        w_ram_din    = 8'h00;
        w_ram_we     = 1'b0;
        w_game_gnt   = 1'b0;
        w_disp_gnt   = 1'b0;
        w_disp_miss  = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_ram_addr  = init_addr;
                w_ram_din   = init_wdata;
                w_ram_we    = init_we;
                w_disp_miss = disp_req;
                if (init_done) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_FILL;
                end
            end
            ST_RUN: begin
                if (disp_req && !w_starve_win) begin
                    w_disp_gnt = 1'b1;
                    w_ram_addr = disp_addr;
                end else if (game_req) begin
                    w_game_gnt  = 1'b1;
                    w_ram_addr  = game_addr;
                    w_ram_din   = game_wdata;
                    w_ram_we    = game_we;
                    w_disp_miss = disp_req;
                end else begin
                    w_ram_addr = r_last_addr;
                end
            end
            default: begin
                w_next_state = ST_FILL;
            end
        endcase
        if (level_start) begin
            w_next_state = ST_FILL;
        end else begin
            w_next_state = w_next_state;
        end
    end

    // State, owner tag and held RAM address registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_FILL;
            r_owner     <= OWN_NONE;
            r_last_addr <= {AW{1'b0}};
        end else begin
            r_state     <= w_next_state;
            r_owner     <= owner_of(w_disp_gnt, w_game_gnt, game_we);
            r_last_addr <= w_ram_addr;
        end
    end

    assign ram_addr    = w_ram_addr;
    assign ram_din     = w_ram_din;
    assign ram_we      = w_ram_we;
    assign game_gnt    = w_game_gnt;
    assign disp_miss   = w_disp_miss;
    assign fill_busy   = (r_state == ST_FILL);
    assign disp_rvalid = (r_owner == OWN_DISP);
    assign game_rvalid = (r_owner == OWN_GAME);
    assign rdata       = ram_dout;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Directed bench for tile_ram_arbiter with a behavioural 1024x8 sync RAM and
// a queue of expected read returns.
module tb_tile_ram_arbiter;

`ifdef TILE_ARB_STARVE_EN
    localparam int unsigned LIM = 4;
`else
    localparam int unsigned LIM = 64;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       level_start, init_we, init_done;
    logic [9:0] init_addr, disp_addr, game_addr;
    logic [7:0] init_wdata, game_wdata;
    logic       disp_req, game_req, game_we;
    logic       fill_busy, disp_miss, game_gnt, game_rvalid, disp_rvalid;
    logic [7:0] rdata, ram_din, ram_dout;
    logic [9:0] ram_addr;
    logic       ram_we;

    logic [7:0] mem [0:1023];

    typedef struct packed {
        logic       is_game;
        logic [7:0] data;
    } exp_rd_t;

    exp_rd_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural synchronous RAM, one cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    tile_ram_arbiter #(.STARVE_LIMIT(LIM), .AW(10)) dut (
        .clk(clk), .reset(reset), .level_start(level_start),
        .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata),
        .init_done(init_done), .fill_busy(fill_busy),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_miss(disp_miss),
        .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
        .game_wdata(game_wdata), .game_gnt(game_gnt), .game_rvalid(game_rvalid),
        .rdata(rdata), .disp_rvalid(disp_rvalid),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Compare this cycle's read return against the scoreboard head.
    task automatic check_read(input string tag);
        exp_rd_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_disp_rvalid"}, {31'd0, disp_rvalid}, 32'd0);
            chk({tag, "_game_rvalid"}, {31'd0, game_rvalid}, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_disp_rvalid"}, {31'd0, disp_rvalid}, {31'd0, ~e.is_game});
            chk({tag, "_game_rvalid"}, {31'd0, game_rvalid}, {31'd0, e.is_game});
            chk({tag, "_rdata"}, {24'd0, rdata}, {24'd0, e.data});
        end
    endtask

    initial begin
        reset = 1'b0; level_start = 1'b0; init_we = 1'b0; init_done = 1'b0;
        init_addr = 10'h000; init_wdata = 8'h00; disp_req = 1'b0;
        disp_addr = 10'h000; game_req = 1'b0; game_we = 1'b0;
        game_addr = 10'h000; game_wdata = 8'h00;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fill_busy", {31'd0, fill_busy}, 32'd1);
        chk("rst_game_gnt", {31'd0, game_gnt}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_disp_miss", {31'd0, disp_miss}, 32'd0);
        check_read("rst");
        reset = 1'b1;

        // Fill: evaluator writes while a game request is held off.
        tick();
        init_we = 1'b1; init_addr = 10'h021; init_wdata = 8'h05;
        game_req = 1'b1; game_addr = 10'h021;
        settle();
        chk("fill_ram_we", {31'd0, ram_we}, 32'd1);
        chk("fill_ram_addr", {22'd0, ram_addr}, 32'h021);
        chk("fill_ram_din", {24'd0, ram_din}, 32'h05);
        chk("fill_game_gnt", {31'd0, game_gnt}, 32'd0);
        tick();
        init_addr = 10'h3FF; init_wdata = 8'hA5; disp_req = 1'b1;
        settle();
        chk("fill_disp_miss", {31'd0, disp_miss}, 32'd1);
        chk("fill_game_gnt2", {31'd0, game_gnt}, 32'd0);
        tick();
        check_read("fill_noread");
        init_we = 1'b0; disp_req = 1'b0; game_req = 1'b0; init_done = 1'b1;
        settle();
        chk("fill_busy_done", {31'd0, fill_busy}, 32'd1);
        tick();
        init_done = 1'b0;
        chk("run_fill_busy", {31'd0, fill_busy}, 32'd0);

        // Display read.
        disp_req = 1'b1; disp_addr = 10'h021;
        settle();
        chk("disp_ram_addr", {22'd0, ram_addr}, 32'h021);
        chk("disp_ram_we", {31'd0, ram_we}, 32'd0);
        chk("disp_miss_run", {31'd0, disp_miss}, 32'd0);
        exp_q.push_back('{is_game: 1'b0, data: 8'h05});
        tick();
        disp_req = 1'b0;
        check_read("disp_rd");
        settle();
        chk("idle_addr_hold", {22'd0, ram_addr}, 32'h021);
        chk("idle_ram_we", {31'd0, ram_we}, 32'd0);

        // Display beats a game write; the write goes once display drops.
        tick();
        disp_req = 1'b1; disp_addr = 10'h3FF;
        game_req = 1'b1; game_we = 1'b1; game_addr = 10'h021; game_wdata = 8'h00;
        settle();
        chk("prio_game_gnt", {31'd0, game_gnt}, 32'd0);
        chk("prio_ram_addr", {22'd0, ram_addr}, 32'h3FF);
        exp_q.push_back('{is_game: 1'b0, data: 8'hA5});
        tick();
        check_read("disp_edge");
        disp_req = 1'b0;
        settle();
        chk("wr_game_gnt", {31'd0, game_gnt}, 32'd1);
        chk("wr_ram_we", {31'd0, ram_we}, 32'd1);
        chk("wr_ram_addr", {22'd0, ram_addr}, 32'h021);
        chk("wr_ram_din", {24'd0, ram_din}, 32'h00);
        tick();
        check_read("wr_noread");
        game_we = 1'b0;
        settle();
        chk("rd_game_gnt", {31'd0, game_gnt}, 32'd1);
        chk("rd_ram_we", {31'd0, ram_we}, 32'd0);
        exp_q.push_back('{is_game: 1'b1, data: 8'h00});
        tick();
        game_req = 1'b0;
        check_read("game_raw");

        // level_start together with a game read grant.
        game_req = 1'b1; game_addr = 10'h3FF; level_start = 1'b1;
        settle();
        chk("ls_game_gnt", {31'd0, game_gnt}, 32'd1);
        exp_q.push_back('{is_game: 1'b1, data: 8'hA5});
        tick();
        level_start = 1'b0;
        check_read("ls_rd");
        chk("ls_fill_busy", {31'd0, fill_busy}, 32'd1);
        chk("ls_no_gnt", {31'd0, game_gnt}, 32'd0);
        tick();
        chk("ls_no_gnt2", {31'd0, game_gnt}, 32'd0);
        check_read("ls_after");

        // Reset in the middle of a granted read discards its return.
        game_req = 1'b0; init_done = 1'b1;
        tick();
        init_done = 1'b0; game_req = 1'b1; game_addr = 10'h021;
        settle();
        chk("mid_gnt", {31'd0, game_gnt}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1; game_req = 1'b0;
        check_read("mid_rst");
        chk("mid_fill_busy", {31'd0, fill_busy}, 32'd1);
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        chk("st_run", {31'd0, fill_busy}, 32'd0);

        // Display and game held together.
        disp_req = 1'b1; disp_addr = 10'h3FF;
        game_req = 1'b1; game_we = 1'b0; game_addr = 10'h021;
`ifdef TILE_ARB_STARVE_EN
        for (int c = 1; c <= 5; c++) begin
            settle();
            chk("starve_gnt", {31'd0, game_gnt}, (c == 5) ? 32'd1 : 32'd0);
            chk("starve_miss", {31'd0, disp_miss}, (c == 5) ? 32'd1 : 32'd0);
            if (c == 5) exp_q.push_back('{is_game: 1'b1, data: 8'h00});
            tick();
        end
        disp_req = 1'b0; game_req = 1'b0;
        check_read("starve_rd");
`else
        for (int c = 1; c <= 100; c++) begin
            settle();
            chk("nostarve_gnt", {31'd0, game_gnt}, 32'd0);
            chk("nostarve_miss", {31'd0, disp_miss}, 32'd0);
            tick();
        end
        disp_req = 1'b0; game_req = 1'b0;
        chk("nostarve_disp_rv", {31'd0, disp_rvalid}, 32'd1);
`endif
        tick();
        check_read("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
